// File: rtl/output_accumulator.sv
// output_accumulator: sums up to BEATS unsigned words per frame and holds the
// frame sum, word count and clamp flag until the consumer takes them.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - upstream word handshake
//   in_data, in_last         - upstream word and end-of-frame marker
//   out_valid/out_ready      - result handshake toward the consumer
//   out_data, out_count      - frame sum and number of words in the frame
//   out_sat                  - frame sum was clamped to all-ones
//
// Build option: define OUTPUT_ACCUMULATOR_SATURATE_EN to clamp on overflow;
// otherwise the sum wraps and out_sat is always 0.
module output_accumulator #(
    parameter int DATA_W = 37,
    parameter int BEATS  = 4,
    parameter int SUM_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_data,
    output logic [7:0]        out_count,
    output logic              out_sat
);

    typedef enum logic {
        ACCUM,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              clamp_q, clamp_d;
    logic [SUM_W-1:0]  res_q, res_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic              rsat_q, rsat_d;

    logic [SUM_W:0]    sum_w;
    logic [SUM_W-1:0]  acc_next;
    logic [7:0]        cnt_inc;
    logic              accept;
    logic              close;
    logic              sat_now;

    // Datapath: one extra bit on the adder exposes the carry-out.
    always_comb begin
        sum_w   = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, in_data};
        cnt_inc = cnt_q + 8'd1;
        accept  = in_valid && (state_q == ACCUM);
        close   = in_last || (cnt_inc == 8'(BEATS));
`ifdef OUTPUT_ACCUMULATOR_SATURATE_EN
        // Once clamped, the accumulator stays all-ones until the frame ends.
        sat_now  = clamp_q | sum_w[SUM_W];
        acc_next = sat_now ? {SUM_W{1'b1}} : sum_w[SUM_W-1:0];
`else
        // clamp_q never leaves its reset value of 0 in this build.
        sat_now  = clamp_q;
        acc_next = sum_w[SUM_W-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        clamp_d = clamp_q;
        res_d   = res_q;
        rcnt_d  = rcnt_q;
        rsat_d  = rsat_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (close) begin
                        res_d   = acc_next;
                        rcnt_d  = cnt_inc;
                        rsat_d  = sat_now;
                        acc_d   = '0;
                        cnt_d   = '0;
                        clamp_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        acc_d   = acc_next;
                        cnt_d   = cnt_inc;
                        clamp_d = sat_now;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            clamp_q <= 1'b0;
            res_q   <= '0;
            rcnt_q  <= '0;
            rsat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            clamp_q <= clamp_d;
            res_q   <= res_d;
            rcnt_q  <= rcnt_d;
            rsat_q  <= rsat_d;
        end
    end

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_count = rcnt_q;
    assign out_sat   = rsat_q;

endmodule

// File: tb/tb_output_accumulator.sv
// Bench for output_accumulator: default instance and a SUM_W=37 instance
// share stimulus and are checked against a frame-level reference model.
module tb_output_accumulator;

    localparam int DW = 37;
    localparam longint unsigned M37 = (64'd1 << 37) - 64'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          rdy0, vld0, sat0, rdy1, vld1, sat1;
    logic [39:0]   d0;
    logic [36:0]   d1;
    logic [7:0]    c0, c1;

    int total = 0;
    int bad = 0;

    bit               m_done;
    longint unsigned  words[$];
    longint unsigned  e_d0, e_d1;
    int               e_cnt;
    bit               e_s0, e_s1;

    output_accumulator u0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last),
        .out_valid(vld0), .out_ready(out_ready),
        .out_data(d0), .out_count(c0), .out_sat(sat0)
    );

    output_accumulator #(.SUM_W(37)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last),
        .out_valid(vld1), .out_ready(out_ready),
        .out_data(d1), .out_count(c1), .out_sat(sat1)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame result from the true (unbounded) sum of the frame's words.
    function automatic void frame_res(longint unsigned s, int w,
                                      output longint unsigned d,
                                      output bit sat);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
`ifdef OUTPUT_ACCUMULATOR_SATURATE_EN
        if (s > mask) begin
            d = mask;
            sat = 1'b1;
        end else begin
            d = s;
            sat = 1'b0;
        end
`else
        d = s & mask;
        sat = 1'b0;
`endif
    endfunction

    // Advance the model across one rising edge using the driven inputs.
    task automatic model_edge();
        longint unsigned s;
        if (rst) begin
            m_done = 1'b0;
            words.delete();
            e_d0 = 0; e_d1 = 0; e_cnt = 0; e_s0 = 0; e_s1 = 0;
        end else if (!m_done) begin
            if (in_valid) begin
                words.push_back(longint'(in_data));
                if (in_last || words.size() == 4) begin
                    s = 0;
                    foreach (words[i]) s += words[i];
                    frame_res(s, 40, e_d0, e_s0);
                    frame_res(s, 37, e_d1, e_s1);
                    e_cnt = words.size();
                    words.delete();
                    m_done = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_done = 1'b0;
        end
    endtask

    task automatic compare();
        chk("rdy0", rdy0, !m_done);
        chk("vld0", vld0, m_done);
        chk("data0", d0, e_d0);
        chk("cnt0", c0, e_cnt);
        chk("sat0", sat0, e_s0);
        chk("rdy1", rdy1, !m_done);
        chk("vld1", vld1, m_done);
        chk("data1", d1, e_d1);
        chk("cnt1", c1, e_cnt);
        chk("sat1", sat1, e_s1);
    endtask

    task automatic step(bit v, longint unsigned d, bit l, bit r, bit x = 1'b0);
        in_valid = v;
        in_data = d[DW-1:0];
        in_last = l;
        out_ready = r;
        rst = x;
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        longint unsigned rd;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_valid", vld0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_data", d0, 0);

        // 1,2,3,4 back to back, then consumer stalls 3 cycles
        for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
        chk("b2b_valid", vld0, 1);
        chk("b2b_data", d0, 10);
        chk("b2b_cnt", c0, 4);
        for (int i = 0; i < 3; i++) begin
            step(1, 9, 0, 0);
            chk("stall_ready", rdy0, 0);
            chk("stall_data", d0, 10);
        end
        step(0, 0, 0, 1);
        chk("rel_valid", vld0, 0);
        chk("rel_ready", rdy0, 1);
        chk("hold_data", d0, 10);

        // 5,6 with last, next frame starts from zero
        step(1, 5, 0, 0);
        step(1, 6, 1, 1);
        chk("last_data", d0, 11);
        chk("last_cnt", c0, 2);
        step(0, 0, 0, 1);
        step(1, 3, 1, 1);
        chk("fresh_data", d0, 3);
        chk("fresh_cnt", c0, 1);
        step(0, 0, 0, 1);

        // last on the 4th word closes exactly one frame
        for (int i = 0; i < 4; i++) step(1, 1, i == 3, 0);
        step(0, 0, 0, 1);
        step(1, 2, 0, 0);
        chk("one_frame", vld0, 0);
        step(1, 2, 1, 0);
        chk("after4_cnt", c0, 2);
        step(0, 0, 0, 1);

        // four all-ones words
        for (int i = 0; i < 4; i++) step(1, M37, 0, 0);
`ifdef OUTPUT_ACCUMULATOR_SATURATE_EN
        chk("ovf_data", d1, M37);
        chk("ovf_sat", sat1, 1);
`else
        chk("ovf_data", d1, M37 - 3);
        chk("ovf_sat", sat1, 0);
`endif
        chk("wide_data", d0, 4 * M37);
        step(0, 0, 0, 1);

        // reset aborts a partial frame
        step(1, 7, 0, 0);
        step(1, 8, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("abort_valid", vld0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        chk("abort_data", d0, 4);
        chk("abort_cnt", c0, 4);
        step(0, 0, 0, 1);

        // idle cycles carry junk data
        for (int i = 0; i < 4; i++) begin
            step(1, 2, 0, 0);
            if (i < 3) step(0, 64'h1F_FFFF_FFFF, 0, 0);
        end
        chk("gap_data", d0, 8);
        step(0, 0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom};
            rd &= M37;
            if ($urandom_range(0, 5) == 0) rd = M37;
            step($urandom_range(0, 3) != 0, rd,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 60) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_accumulator.md
OUTPUT_ACCUMULATOR -- requirements
Module: output_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 37, width of each input word (matches the 37-bit upstream output word).
REQ-002 The block SHALL have parameter BEATS, default 4, maximum number of words summed per frame (legal range 2..255).
REQ-003 The block SHALL have parameter SUM_W, default 40, accumulator and result width, with SUM_W >= DATA_W.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-006 The block SHALL have port in_valid, input, 1, upstream word present.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W, upstream word, treated as unsigned.
REQ-009 The block SHALL have port in_last, input, 1, marks the accepted word as the final word of the current frame.
REQ-010 The block SHALL have port out_valid, output, 1, result held for the consumer.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 The block SHALL have port out_data, output, SUM_W, frame sum.
REQ-013 The block SHALL have port out_count, output, 8, number of words in the reported frame.
REQ-014 The block SHALL have port out_sat, output, 1, frame sum was clamped.

Function
REQ-015 The block SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1); in_ready and out_valid are registered, not combinational functions of the inputs.
REQ-016 A word SHALL be accepted only when in_valid and in_ready are both 1; an accepted word adds zero-extended in_data to the accumulator and increments the beat counter.
REQ-017 A frame SHALL close on the accepted word that is the BEATS-th word, or that has in_last=1, whichever comes first; in_last on the BEATS-th word closes exactly one frame.
REQ-018 On frame close, the block SHALL load out_data with the sum including the closing word, load out_count with the word count, set out_valid the following cycle (latency 1), clear the accumulator and counter, and enter DONE.
REQ-019 In DONE, out_data, out_count and out_sat SHALL stay stable while out_ready=0, and in_valid SHALL be ignored.
REQ-020 In DONE with out_ready=1, the block SHALL clear out_valid and return to ACCUM at the next edge; in_ready SHALL rise in that same next cycle, with no same-cycle bypass.
REQ-021 Without saturation, the sum SHALL wrap modulo 2^SUM_W.
REQ-022 out_data and out_count SHALL hold their last values after the handshake until the next frame closes.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL enter ACCUM and set the accumulator=0, counter=0, out_valid=0, out_data=0, out_count=0 and out_sat=0; in_ready SHALL be 1 in the first cycle after reset.
REQ-024 A reset mid-frame or in DONE SHALL discard any partial sum or pending result without producing out_valid.

Configuration
REQ-025 With macro OUTPUT_ACCUMULATOR_SATURATE_EN defined, an addition that overflows SUM_W bits SHALL clamp the accumulator to all-ones for the rest of the frame, and out_sat SHALL be 1 for that frame's result.
REQ-026 Without OUTPUT_ACCUMULATOR_SATURATE_EN, the sum SHALL wrap per REQ-021, and out_sat SHALL be tied to 0.

Verification
REQ-027 The bench SHALL cover this case: defaults, words 1,2,3,4 back-to-back -> out_data=10, out_count=4, out_valid one cycle after the 4th accept.
REQ-028 The bench SHALL cover this case: words 5,6 with in_last on 6 -> out_data=11, out_count=2; the next frame starts from 0.
REQ-029 The bench SHALL cover this case: out_ready held 0 for 3 cycles after close -> out_data stable and in_ready=0 throughout; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-030 The bench SHALL cover this case: SUM_W=37, four words of 2^37-1 -> with the macro out_data=2^37-1 and out_sat=1; without it out_data=2^37-4 and out_sat=0.
REQ-031 The bench SHALL cover this case: words 7,8, then rst for one cycle, then words 1,1,1,1 -> a single result with out_data=4, out_count=4, and no result for the aborted frame.
REQ-032 The bench SHALL cover this case: in_valid toggling every other cycle with words 2,2,2,2 -> out_data=8, with idle cycles adding nothing.
